// File: rtl/voxel_pixel_sink.sv
// rtl/voxel_pixel_sink.sv - pixel-write FIFO and double-buffered framebuffer writer with deferred buffer flip
module voxel_pixel_sink #(
    parameter int SCREEN_WIDTH  = 480,
    parameter int SCREEN_HEIGHT = 360,
    parameter int ADDR_W        = 18,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pix_write_en,
    input  logic [31:0]                   pix_addr,
    input  logic [31:0]                   pix_word0,
    input  logic [31:0]                   pix_word1,
    input  logic [31:0]                   pix_word2,
    input  logic                          frame_done,
    output logic                          mem_wvalid,
    input  logic                          mem_wready,
    output logic [ADDR_W:0]               mem_waddr,
    output logic [95:0]                   mem_wdata,
    output logic                          front_buf,
    output logic                          frame_commit,
    output logic [31:0]                   frame_pixel_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          range_err,
    output logic                          seq_err,
    input  logic                          clear_status
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [31:0]   NUM_PIX = 32'(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_COMMIT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [95:0]       r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [LW-1:0]     r_remaining;
    logic              r_pending;
    logic [31:0]       r_frame_cnt;
    logic [31:0]       r_snap_cur;
    logic [31:0]       r_snap_pend;
    logic              r_front;
    logic [31:0]       r_count_out;
    logic              r_overflow;
    logic              r_range_err;
    logic              r_seq_err;

    logic              w_in_range;
    logic              w_full;
    logic              w_wvalid;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_rng_set;
    logic              w_seq_set;
    logic [LW-1:0]     w_level_nxt;
    logic [31:0]       w_snap;

    assign w_in_range  = pix_addr < NUM_PIX;
    assign w_full      = r_level == DEPTH_L;
    // Entries behind the frame boundary stay queued until the flip has happened.
    assign w_wvalid    = ((r_state == S_RUN)   && (r_level != '0)) ||
                         ((r_state == S_DRAIN) && (r_level != '0) && (r_remaining != '0));
    assign w_pop       = w_wvalid && mem_wready;
    assign w_push      = pix_write_en && w_in_range && (!w_full || w_pop);
    assign w_ovf_set   = pix_write_en && w_in_range && w_full && !w_pop;
    assign w_rng_set   = pix_write_en && !w_in_range;
    assign w_seq_set   = frame_done && r_pending;
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
    assign w_snap      = r_frame_cnt + 32'(w_push);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (frame_done) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_remaining == '0) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = (r_pending || frame_done) ? S_DRAIN : S_RUN;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= pix_addr[ADDR_W-1:0];
            r_fifo_data[r_wr_ptr] <= {pix_word2, pix_word1, pix_word0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_remaining <= '0;
            r_pending   <= 1'b0;
            r_frame_cnt <= '0;
            r_snap_cur  <= '0;
            r_snap_pend <= '0;
            r_front     <= 1'b0;
            r_count_out <= '0;
            r_overflow  <= 1'b0;
            r_range_err <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);

            if (frame_done)  r_frame_cnt <= '0;
            else if (w_push) r_frame_cnt <= r_frame_cnt + 32'd1;

            case (r_state)
                S_RUN: begin
                    if (frame_done) begin
                        r_remaining <= w_level_nxt;
                        r_snap_cur  <= w_snap;
                    end
                end
                S_DRAIN: begin
                    if (w_pop) r_remaining <= r_remaining - LW'(1);
                    if (frame_done) begin
                        r_pending   <= 1'b1;
                        r_snap_pend <= w_snap;
                    end
                end
                S_COMMIT: begin
                    r_front     <= ~r_front;
                    r_count_out <= r_snap_cur;
                    r_pending   <= 1'b0;
                    // A done arriving now supersedes any stored one and starts the next drain.
                    if (frame_done) begin
                        r_remaining <= w_level_nxt;
                        r_snap_cur  <= w_snap;
                    end else if (r_pending) begin
                        r_remaining <= r_level;
                        r_snap_cur  <= r_snap_pend;
                    end
                end
                default: ;
            endcase

            r_overflow  <= w_ovf_set | (r_overflow  & ~clear_status);
            r_range_err <= w_rng_set | (r_range_err & ~clear_status);
            r_seq_err   <= w_seq_set | (r_seq_err   & ~clear_status);
        end
    end

    assign mem_wvalid        = w_wvalid;
    assign mem_waddr         = w_wvalid ? {~r_front, r_fifo_addr[r_rd_ptr]} : '0;
    assign mem_wdata         = w_wvalid ? r_fifo_data[r_rd_ptr] : '0;
    assign front_buf         = r_front;
    assign frame_commit      = r_state == S_COMMIT;
    assign frame_pixel_count = r_count_out;
    assign fifo_level        = r_level;
    assign overflow          = r_overflow;
    assign range_err         = r_range_err;
    assign seq_err           = r_seq_err;

endmodule

// File: doc/voxel_pixel_sink.md
# voxel_pixel_sink

Receiving end of the raycaster pixel-write stream. Accepts the unthrottled per-pixel writes and the frame-done pulse from the voxel framebuffer top and buffers them in a small FIFO. It drains them into a double-buffered framebuffer memory through a valid/ready write port, and flips the displayed buffer only after every pixel of a finished frame has been written.

## Interface
Parameters:
- SCREEN_WIDTH, 480: pixels per line.
- SCREEN_HEIGHT, 360: lines per frame.
- ADDR_W, 18: per-buffer pixel index width. Must satisfy 2^ADDR_W >= SCREEN_WIDTH*SCREEN_HEIGHT.
- FIFO_DEPTH, 16: entries, power of two.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pix_write_en  in  1  one pixel per cycle while high; no backpressure.
- pix_addr  in  32  linear pixel index.
- pix_word0 / pix_word1 / pix_word2  in  32 each  pixel payload.
- frame_done  in  1  single-cycle pulse; ends the current frame.
- mem_wvalid  out  1  write request.
- mem_wready  in  1  memory accepts.
- mem_waddr  out  ADDR_W+1  {buffer select, pixel index}.
- mem_wdata  out  96  {word2, word1, word0}.
- front_buf  out  1  buffer currently displayed.
- frame_commit  out  1  one-cycle pulse when a frame becomes visible.
- frame_pixel_count  out  32  pixels accepted in the last committed frame.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: pixel dropped because the FIFO was full.
- range_err  out  1  sticky: pixel dropped because pix_addr >= SCREEN_WIDTH*SCREEN_HEIGHT.
- seq_err  out  1  sticky: frame_done arrived while a second done was already pending.
- clear_status  in  1  clears overflow, range_err and seq_err.

## Operation
- Push: when pix_write_en is high, the address is in range and the FIFO is not full, store {pix_addr[ADDR_W-1:0], words} and increment the frame counter.
- Drops: a full FIFO sets overflow. An out-of-range address sets range_err. Neither drop counts as a pixel.
- FIFO is first-word-fall-through. mem_waddr = {~front_buf, head index}; the buffer bit is computed at pop time, not push time.
- Pop: occurs when mem_wvalid && mem_wready.
- States:
  - RUN: mem_wvalid = level != 0.
  - DRAIN: mem_wvalid = (level != 0) && (remaining != 0). remaining decrements on each pop. When remaining == 0, go to COMMIT.
  - COMMIT: mem_wvalid = 0. frame_commit = 1. front_buf toggles and frame_pixel_count loads the snapshot. Next state is DRAIN if pending_done is set (remaining = current level, pending cleared), else RUN.
- frame_done in RUN: go to DRAIN.
  - remaining = next-cycle level (level + push - pop of that same cycle).
  - Count snapshot = counter including the same-cycle push; counter is reset to 0.
- frame_done in DRAIN or COMMIT: set pending_done and store the second snapshot.
  - Its remaining is computed when COMMIT exits.
  - If pending_done is already set, also set seq_err. The newest snapshot overwrites the stored one.
- Same-cycle pix_write_en and frame_done: the pixel belongs to the ending frame.
- Pixels arriving during DRAIN/COMMIT are pushed normally. In-order popping guarantees they are written after the flip, into the new back buffer.
- Sticky flags: if clear_status and a new error occur in the same cycle, the error wins.

## Timing
- Reset values:
  - front_buf = 0; mem_wvalid = 0; mem_waddr = 0; mem_wdata = 0.
  - frame_commit = 0; frame_pixel_count = 0; fifo_level = 0.
  - All sticky flags = 0; state = RUN; FIFO empty; pending cleared.
- Reset mid-frame discards all FIFO content and any pending frame.
- Latency: a push sampled at edge k gives earliest mem_wvalid in the cycle after edge k.
- Handshake: while mem_wvalid && !mem_wready, mem_waddr and mem_wdata are held stable. mem_wvalid never drops without a pop, except on reset.
- Empty FIFO, frame_done sampled at edge k:
  - DRAIN during cycle k+1.
  - COMMIT (frame_commit = 1) during cycle k+2.
  - New front_buf visible from cycle k+3.
- Non-empty FIFO: frame_commit is asserted in the second cycle after the handshake that popped the last pre-done entry.
- Throughput: 1 pixel/cycle sustained when mem_wready is held high, apart from the COMMIT bubble.
- FIFO full: a simultaneous pop and push is allowed; level stays at FIFO_DEPTH and nothing is dropped.

## Test plan
- Basic write: ready=1; 5 pixels at addrs 0–4, then frame_done -> 5 writes with mem_waddr = {1, addr} and matching data; one frame_commit pulse; front_buf=1; frame_pixel_count=5.
- Backpressure: ready=0 while 20 consecutive pixels arrive with FIFO_DEPTH=16 -> exactly 16 stored; overflow=1; level=16. Releasing ready gives 16 in-order writes with data held stable while stalled.
- Late pixels: 3 pixels, frame_done, then 2 pixels immediately, with ready toggled 1/0 -> first 3 written to buffer 1; commit; last 2 written with buffer bit 0; count=3.
- Boundary: pix_addr=172800 (480x360 default) -> dropped and range_err=1. pix_addr=172799 -> written. clear_status -> flags 0.
- Double done: frame_done twice, 2 cycles apart, with 4 pixels in the FIFO and ready=0 -> no commit until ready. Then two commit pulses; front_buf returns to 0; seq_err=0. A third done while still pending -> seq_err=1.
- Reset mid-DRAIN: assert rst_n low with 8 entries queued -> all outputs at reset values; no writes after release.
